// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants and types for the main-memory port arbiter. It holds:
//   - the default sizing (requester count, index width, hold limit, counter width)
//   - the arbiter state encoding
//   - the requester index constants (PROC1..PROC8 map to the 4 cores x I/D)
//   - small helpers for one-hot grant encoding and modulo pointer stepping
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int N_REQ    = 8;   // round-robin requesters
  localparam int PTR_W    = 3;   // width of a requester index
  localparam int MAX_HOLD = 64;  // longest a round-robin grant may be held
  localparam int CNT_W    = 7;   // hold counter width, must reach MAX_HOLD-1

  // Arbiter states. IDLE is the only state in which arbitration happens.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HP    = 2'd2,
    TURN  = 2'd3
  } state_t;

  // Requester index constants (core0 I/D, core1 I/D, ...).
  localparam int PROC1 = 0;
  localparam int PROC2 = 1;
  localparam int PROC3 = 2;
  localparam int PROC4 = 3;
  localparam int PROC5 = 4;
  localparam int PROC6 = 5;
  localparam int PROC7 = 6;
  localparam int PROC8 = 7;

  // One-hot grant vector for a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] id);
    return {{(N_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  // Index following id, wrapping at N_REQ (works for non-power-of-two counts).
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] id);
    return PTR_W'((int'(id) + 1) % N_REQ);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Request/grant bundle between the L1 controllers (plus the snoop writeback
// path) and the main-memory port arbiter.
//   req       N_REQ  level request per round-robin requester
//   hp_req    1      high-priority snoop writeback/flush request, level
//   gnt       N_REQ  one-hot grant, registered
//   hp_gnt    1      high-priority grant, registered
//   gnt_valid 1      any gnt bit set
//   gnt_id    PTR_W  index of the granted requester, 0 when none
//   timeout   1      one-cycle pulse after a grant is revoked by the hold limit
//   busy      1      arbiter not in IDLE
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             hp_req;
  logic [N_REQ-1:0] gnt;
  logic             hp_gnt;
  logic             gnt_valid;
  logic [PTR_W-1:0] gnt_id;
  logic             timeout;
  logic             busy;

  modport master (
    output req,
    output hp_req,
    input  gnt,
    input  hp_gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout,
    input  busy
  );

  modport slave (
    input  req,
    input  hp_req,
    output gnt,
    output hp_gnt,
    output gnt_valid,
    output gnt_id,
    output timeout,
    output busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority finder. Scans req starting at rr_ptr and
// wrapping modulo N, and returns the first set index.
//   req     in  N  request vector
//   rr_ptr  in  W  index that currently has highest priority
//   any     out 1  at least one request is set
//   pick_id out W  winning index (0 when any=0)
// Kept free of arbiter state so the snoop-bus arbiter can reuse it.
// -----------------------------------------------------------------------------
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int W = PTR_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         any,
  output logic [W-1:0] pick_id
);

  // cand_id[k] is the index examined at priority position k; cand_req[k] is
  // its request bit. Position 0 is the highest priority.
  logic [W-1:0] cand_id [N];
  logic [N-1:0] cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign cand_id[gi]  = W'((int'(rr_ptr) + gi) % N);
      assign cand_req[gi] = req[cand_id[gi]];
    end
  endgenerate

  assign any = |req;

  // Walk from lowest to highest priority so the last hit (highest priority)
  // wins; avoids a break and synthesises to a plain priority mux.
  always_comb begin
    pick_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        pick_id = cand_id[i];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single main-memory port between 8 L1 controllers (round-robin)
// and the high-priority snoop writeback path.
//   clk  in   system clock, all logic on posedge
//   rst  in   synchronous active-high reset
//   bus  slave modport of mem_port_arbiter_if (req/hp_req in,
//        gnt/hp_gnt/gnt_valid/gnt_id/timeout/busy out, all registered)
// Behaviour summary:
//   - Arbitration only in IDLE; hp_req beats any round-robin request.
//   - A round-robin grant is held while its req stays high, for at most
//     MAX_HOLD cycles; a forced revocation pulses timeout for one cycle.
//   - hp grants are held while hp_req stays high, with no limit, and never
//     preempt a round-robin grant.
//   - Every grant release is followed by a TURN cycle, then IDLE, giving at
//     least two dead cycles for bus turnaround.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  mem_port_arbiter_if.slave         bus
);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic [PTR_W-1:0] rr_ptr_reg;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic             hp_gnt_reg;
  logic             gnt_valid_reg;
  logic [PTR_W-1:0] gnt_id_reg;
  logic             timeout_reg;
  logic             busy_reg;

  // ---------------------------------------------------------------------------
  // Round-robin pick for the IDLE arbitration
  // ---------------------------------------------------------------------------
  logic             pick_any;
  logic [PTR_W-1:0] pick_id;

  rr_pick #(
    .N (N_REQ),
    .W (PTR_W)
  ) u_rr_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_reg),
    .any     (pick_any),
    .pick_id (pick_id)
  );

  // ---------------------------------------------------------------------------
  // Grant release conditions while in GRANT
  // ---------------------------------------------------------------------------
  logic             owner_req;
  logic             hold_expired;
  logic             release_grant;
  logic [PTR_W-1:0] rr_ptr_next;

  assign owner_req     = bus.req[gnt_id_reg];
  // hold_cnt is 0 on the first granted cycle, so reaching MAX_HOLD-1 means
  // the grant has been visible for exactly MAX_HOLD cycles.
  assign hold_expired  = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
  assign release_grant = !owner_req || hold_expired;
  // The requester after the one being released gets first look next time.
  assign rr_ptr_next   = next_idx(gnt_id_reg);

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      hold_cnt_reg  <= '0;
      gnt_reg       <= '0;
      hp_gnt_reg    <= 1'b0;
      gnt_valid_reg <= 1'b0;
      gnt_id_reg    <= '0;
      timeout_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      // timeout is a single-cycle pulse; only the revoking edge sets it.
      timeout_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.hp_req) begin
            state_reg  <= HP;
            hp_gnt_reg <= 1'b1;
            busy_reg   <= 1'b1;
          end else if (pick_any) begin
            state_reg     <= GRANT;
            gnt_reg       <= onehot(pick_id);
            gnt_id_reg    <= pick_id;
            gnt_valid_reg <= 1'b1;
            hold_cnt_reg  <= '0;
            busy_reg      <= 1'b1;
          end
        end

        GRANT: begin
          if (release_grant) begin
            state_reg     <= TURN;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            gnt_id_reg    <= '0;
            hold_cnt_reg  <= '0;
            rr_ptr_reg    <= rr_ptr_next;
            // A voluntary drop takes precedence: only a requester still
            // asking at the limit sees the timeout.
            timeout_reg   <= owner_req;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end

        HP: begin
          if (!bus.hp_req) begin
            state_reg  <= TURN;
            hp_gnt_reg <= 1'b0;
          end
        end

        TURN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.gnt       = gnt_reg;
  assign bus.hp_gnt    = hp_gnt_reg;
  assign bus.gnt_valid = gnt_valid_reg;
  assign bus.gnt_id    = gnt_id_reg;
  assign bus.timeout   = timeout_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by a randomized phase. Every cycle the DUT
// outputs are compared with a reference model that tracks who owns the port,
// how long it has held it and how many dead cycles remain before the next
// arbitration.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner -1 = nobody, 0..N_REQ-1 = round-robin requester,
  // N_REQ = snoop path. held = cycles the current grant has been visible.
  // gap = dead cycles still to pass before arbitration resumes.
  int   m_owner   = -1;
  int   m_gap     = 0;
  int   m_held    = 0;
  int   m_ptr     = 0;
  logic m_timeout = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rs, input logic [N_REQ-1:0] r, input logic h);
    m_timeout = 1'b0;
    if (rs) begin
      m_owner = -1; m_gap = 0; m_held = 0; m_ptr = 0;
    end else if (m_owner >= 0 && m_owner < N_REQ) begin
      if (!r[m_owner] || m_held == MAX_HOLD) begin
        m_timeout = r[m_owner];
        m_ptr     = (m_owner + 1) % N_REQ;
        m_owner   = -1;
        m_held    = 0;
        m_gap     = 1;
      end else begin
        m_held++;
      end
    end else if (m_owner == N_REQ) begin
      if (!h) begin
        m_owner = -1;
        m_gap   = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (h) begin
      m_owner = N_REQ;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N_REQ]) begin
          m_owner = (m_ptr + k) % N_REQ;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [31:0] e_gnt;
    logic        rr_own;
    rr_own = (m_owner >= 0 && m_owner < N_REQ);
    e_gnt  = rr_own ? (32'd1 << m_owner) : 32'd0;
    chk("gnt",       32'(bus.gnt),       e_gnt);
    chk("hp_gnt",    32'(bus.hp_gnt),    32'(m_owner == N_REQ));
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(rr_own));
    chk("gnt_id",    32'(bus.gnt_id),    rr_own ? 32'(m_owner) : 32'd0);
    chk("timeout",   32'(bus.timeout),   32'(m_timeout));
    chk("busy",      32'(bus.busy),      32'(m_owner != -1 || m_gap > 0));
    chk("one_owner", 32'($countones({bus.gnt, bus.hp_gnt}) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, bus.req, bus.hp_req);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int starts, run, gap, prev_valid, first_run, touts, waited, plan_len, last_owner;

    bus.req = '0;
    bus.hp_req = 1'b0;

    // ---- 1: reset, single request, release, pointer advances to 3 ----
    rst = 1'b1; ticks(2);
    chk("t1_rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    bus.req = 8'b0000_0100; tick();
    chk("t1_gnt", 32'(bus.gnt), 32'h04);
    chk("t1_id", 32'(bus.gnt_id), 32'd2);
    ticks(3);
    bus.req = '0; tick();
    chk("t1_drop", 32'(bus.gnt), 32'd0);
    chk("t1_turn_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.req = 8'b0000_1001; tick();
    chk("t1_ptr3", 32'(bus.gnt_id), 32'd3);
    bus.req = '0; ticks(3);

    // ---- 2: all requesting, each holds 5 cycles, order 0..7,0 ----
    rst = 1'b1; tick(); rst = 1'b0;
    starts = 0; run = 0; gap = 0; prev_valid = 0;
    for (int c = 0; c < 200 && starts < 9; c++) begin
      bus.req = 8'hFF;
      if (m_owner >= 0 && m_owner < N_REQ && m_held == 5) bus.req[m_owner] = 1'b0;
      tick();
      if (bus.gnt_valid && !prev_valid) begin
        if (starts > 0) chk("t2_gap", 32'(gap), 32'd2);
        chk("t2_order", 32'(bus.gnt_id), 32'(starts % N_REQ));
        starts++;
        run = 0;
      end
      if (bus.gnt_valid) run++;
      else begin
        if (prev_valid) begin chk("t2_width", 32'(run), 32'd5); gap = 0; end
        gap++;
      end
      prev_valid = int'(bus.gnt_valid);
    end
    if (starts < 9) chk("t2_budget", 32'(starts), 32'd9);
    bus.req = '0; ticks(3);

    // ---- 3: req[3] held 100 cycles, hold limit 64 ----
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 8'h08;
    run = 0; first_run = -1; touts = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.gnt[3]) run++;
      else if (run > 0 && first_run < 0) first_run = run;
      if (bus.timeout) touts++;
    end
    chk("t3_width", 32'(first_run), 32'd64);
    chk("t3_timeouts", 32'(touts), 32'd1);
    bus.req = '0; ticks(3);

    // ---- 4: hp request during grant of 5 waits for completion ----
    bus.req = 8'h20; tick();
    chk("t4_gnt5", 32'(bus.gnt_id), 32'd5);
    ticks(2);
    bus.hp_req = 1'b1; bus.req = 8'h60; ticks(3);
    chk("t4_no_preempt", 32'(bus.hp_gnt), 32'd0);
    bus.req = 8'h40; ticks(2);
    tick();
    chk("t4_hp", 32'(bus.hp_gnt), 32'd1);
    chk("t4_hp_gnt0", 32'(bus.gnt), 32'd0);
    ticks(2);
    bus.hp_req = 1'b0; ticks(3);
    chk("t4_gnt6", 32'(bus.gnt), 32'h40);

    // ---- 5: reset mid-grant, pointer back to 0 ----
    bus.req = 8'h10; ticks(3);
    chk("t5_gnt4", 32'(bus.gnt_id), 32'd4);
    ticks(2);
    rst = 1'b1; tick();
    chk("t5_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0; bus.req = 8'h81; tick();
    chk("t5_gnt0", 32'(bus.gnt), 32'h01);

    // ---- 6: hp and req[4] together in IDLE ----
    bus.req = '0; ticks(3);
    bus.hp_req = 1'b1; bus.req = 8'h10; tick();
    chk("t6_hp", 32'(bus.hp_gnt), 32'd1);
    chk("t6_gnt0", 32'(bus.gnt), 32'd0);
    tick();
    bus.hp_req = 1'b0;
    waited = 0;
    while (!bus.gnt_valid && waited < 10) begin tick(); waited++; end
    chk("t6_wait", 32'(waited), 32'd3);
    chk("t6_gnt4", 32'(bus.gnt_id), 32'd4);

    // ---- Random phase ----
    plan_len = 1; last_owner = m_owner;
    for (int c = 0; c < 4000; c++) begin
      if (m_owner != last_owner && m_owner >= 0 && m_owner < N_REQ)
        plan_len = $urandom_range(1, 80);
      last_owner = m_owner;
      for (int i = 0; i < N_REQ; i++) begin
        if (m_owner == i) begin
          if (m_held >= plan_len) bus.req[i] = 1'b0;
        end else if (bus.req[i]) begin
          if ($urandom_range(0, 9) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          bus.req[i] = 1'b1;
        end
      end
      if (bus.hp_req) begin
        if ($urandom_range(0, (m_owner == N_REQ) ? 9 : 5) == 0) bus.hp_req = 1'b0;
      end else if ($urandom_range(0, 24) == 0) begin
        bus.hp_req = 1'b1;
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares the single main-memory port among the L1 cache controllers (4 cores x I/D = 8 requesters).
- Also serves one high-priority requester: the memory-snoop writeback/flush path.
- Holds each grant until the requester drops its request, with a hold timeout for fairness. Inserts a fixed dead period between grants so the memory bus can turn around.

Parameters:
- N_REQ, 8, number of round-robin requesters.
- PTR_W, 3, width of requester index (log2 N_REQ).
- MAX_HOLD, 64, maximum cycles one round-robin grant may be held.
- CNT_W, 7, hold counter width (must hold MAX_HOLD-1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester memory request, level, held until done.
- hp_req  in  1  high-priority snoop writeback request, level.
- gnt  out  N_REQ  one-hot grant, registered.
- hp_gnt  out  1  high-priority grant, registered.
- gnt_valid  out  1  1 while any bit of gnt is set.
- gnt_id  out  PTR_W  index of granted requester; 0 when gnt_valid=0.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - gnt=0, hp_gnt=0, gnt_valid=0, gnt_id=0, timeout=0, busy=0.
  - rr_ptr=0, hold_cnt=0, state=IDLE.
  - Reset mid-grant drops the grant at that same edge. No request is remembered.
- States: IDLE, GRANT, HP, TURN. All outputs are registered.
- IDLE:
  - hp_req=1 -> next state HP, hp_gnt=1. hp_req wins over any req asserted in the same cycle.
  - Else if req!=0 -> pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ. Set gnt one-hot, gnt_id, gnt_valid=1, hold_cnt=0; next state GRANT.
  - Latency: req sampled at edge k, gnt visible from edge k.
- GRANT:
  - hold_cnt increments every cycle.
  - req[gnt_id]=0 -> clear gnt, gnt_valid, gnt_id; rr_ptr=(gnt_id+1) mod N_REQ (wrap 7->0); next state TURN.
  - Else if hold_cnt==MAX_HOLD-1 -> same revocation, plus timeout=1 for exactly the next cycle. Grant width is therefore exactly MAX_HOLD cycles.
  - hp_req never preempts a grant. It is served at the next IDLE arbitration.
  - Changes on other req bits have no effect.
- HP:
  - hp_gnt held while hp_req=1. No timeout applies.
  - hp_req=0 -> hp_gnt=0, next state TURN; rr_ptr unchanged.
- TURN: one dead cycle, all grants 0, next state IDLE. Minimum grant-to-grant gap is 2 low cycles (TURN + IDLE).
- A requester that drops and re-raises req within its grant is not detected. Only the level at the sampling edge counts.
- A request newly raised in TURN is considered at the following IDLE edge.
- Invariant: at most one of {gnt bits, hp_gnt} set in any cycle.
- All index arithmetic is modulo N_REQ. hold_cnt is compared unsigned and saturates never, because revocation happens first.

Decomposition:
- Package mem_arb_pkg:
  - state localparams IDLE=2'd0, GRANT=2'd1, HP=2'd2, TURN=2'd3;
  - default N_REQ/PTR_W/MAX_HOLD;
  - requester index constants PROC1..PROC8 -> 0..7.
- Sub-module rr_pick: combinational rotate-priority finder. Inputs req, rr_ptr; outputs any, pick_id. Reused by the future snoop-bus arbiter.
- Top holds the FSM, counter, pointer and output registers.

Test Plan:
1. Reset, then req=8'b0000_0100 -> gnt=8'b0000_0100, gnt_id=2, gnt_valid=1 from the sampling edge. Drop req -> gnt=0 next edge, one TURN cycle, rr_ptr=3.
2. req=8'hFF, each requester drops req 5 cycles after its grant -> grant order 0,1,...,7,0. Each grant is 5 cycles wide with 2 dead cycles between grants.
3. req[3] held 100 cycles, MAX_HOLD=64 -> gnt[3] high exactly 64 cycles; timeout=1 for one cycle; req[3] regranted only after other requesters are scanned (alone: after TURN+IDLE).
4. Grant on 5 active, hp_req=1 and req[6]=1 arrive -> grant 5 runs to completion. Then TURN, IDLE, then hp_gnt=1 (req[6] waits). After hp_req drops, TURN, IDLE, then gnt[6].
5. rst=1 mid-grant of 4 -> all outputs 0 at that edge, busy=0. Release rst with req=8'h81 -> gnt[0] (rr_ptr reset to 0).
6. IDLE with hp_req=1 and req=8'h10 in the same cycle -> hp_gnt=1, gnt=0. After hp_req drops -> gnt[4].
